test_pattern_gen: RTL and testbench

- Parametrised video timing and test-pattern generator; successor to the fixed 910x262 ramp generator.
- Produces configurable H/V timing with registered HS/VS/DE.
- Produces a selectable RGB pattern: legacy ramp, colour bars, checker, crosshatch, solid, moving bar.
- Sits at the head of the TG video path and feeds the character overlay and encoders; external vertical reset keeps the legacy restart function.

---
 rtl/test_pattern_gen.sv | 209 ++++++++++++++++++++
 tb/tb_test_pattern_gen.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_pattern_gen.sv
// Video timing and test-pattern generator: programmable H/V timing with registered
// syncs, plus ramp, colour bars, checker, crosshatch, solid and moving-bar patterns.
module test_pattern_gen #(
    parameter int C_W          = 8,
    parameter int HW           = 10,
    parameter int VW           = 10,
    parameter int FW           = 8,
    parameter int H_TOTAL      = 858,
    parameter int H_ACT        = 720,
    parameter int H_SYNC_START = 736,
    parameter int H_SYNC_LEN   = 62,
    parameter int V_TOTAL      = 525,
    parameter int V_ACT        = 480,
    parameter int V_SYNC_START = 489,
    parameter int V_SYNC_LEN   = 6,
    parameter int BAR_W        = 90
) (
    input  logic                 CK_i,
    input  logic                 RST_i,
    input  logic                 CK_EE_i,
    input  logic                 XVRST_i,
    input  logic [2:0]           MODE_i,
    input  logic [3*C_W-1:0]     SOLID_i,
    output logic                 HS_o,
    output logic                 VS_o,
    output logic                 DE_o,
    output logic [C_W-1:0]       QQs_R_o,
    output logic [C_W-1:0]       QQs_G_o,
    output logic [C_W-1:0]       QQs_B_o,
    output logic [HW-1:0]        HCTRs_o,
    output logic [VW-1:0]        VCTRs_o,
    output logic [FW-1:0]        FCTRs_o,
    output logic                 FRAME_o
);

    localparam int BCW = $clog2(BAR_W + 1);

    localparam logic [HW-1:0]  L_H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]  L_H_ACT    = HW'(H_ACT);
    localparam logic [HW-1:0]  L_H_ACT_M1 = HW'(H_ACT - 1);
    localparam logic [HW-1:0]  L_HS_ON    = HW'(H_SYNC_START);
    localparam logic [HW-1:0]  L_HS_OFF   = HW'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [VW-1:0]  L_V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]  L_V_ACT    = VW'(V_ACT);
    localparam logic [VW-1:0]  L_V_ACT_M1 = VW'(V_ACT - 1);
    localparam logic [VW-1:0]  L_VS_ON    = VW'(V_SYNC_START);
    localparam logic [VW-1:0]  L_VS_OFF   = VW'(V_SYNC_START + V_SYNC_LEN);
    localparam logic [BCW-1:0] L_BAR_LAST = BCW'(BAR_W - 1);

    logic [HW-1:0]  r_h;
    logic [VW-1:0]  r_v;
    logic [FW-1:0]  r_f;
    logic           r_xv;
    logic [2:0]     r_mode;
    logic [BCW-1:0] r_bar_cnt;
    logic [2:0]     r_bar_idx;

    logic           w_restart;
    logic           w_h_last;
    logic           w_v_last;
    logic           w_sof;
    logic [2:0]     w_mode;

    assign w_restart = r_xv & ~XVRST_i;
    assign w_h_last  = (r_h == L_H_LAST);
    assign w_v_last  = (r_v == L_V_LAST);
    assign w_sof     = (r_h == '0) && (r_v == '0);
    // The first pixel of a frame already uses the mode being latched on that cycle.
    assign w_mode    = w_sof ? MODE_i : r_mode;

    // Counters, restart detector and mode latch
    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            r_h       <= '0;
            r_v       <= '0;
            r_f       <= '0;
            r_xv      <= 1'b1;
            r_mode    <= '0;
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
        end else if (CK_EE_i) begin
            r_xv <= XVRST_i;
            if (w_restart) begin
                r_h       <= '0;
                r_v       <= '0;
                r_mode    <= MODE_i;
                r_bar_cnt <= '0;
                r_bar_idx <= '0;
            end else begin
                if (w_sof) begin
                    r_mode <= MODE_i;
                end
                if (w_h_last) begin
                    r_h       <= '0;
                    r_bar_cnt <= '0;
                    r_bar_idx <= '0;
                    if (w_v_last) begin
                        r_v <= '0;
                        r_f <= r_f + FW'(1);
                    end else begin
                        r_v <= r_v + VW'(1);
                    end
                end else begin
                    r_h <= r_h + HW'(1);
                    // Bar index tracks H/BAR_W without a divider, saturating at the black bar.
                    if (r_bar_cnt == L_BAR_LAST) begin
                        r_bar_cnt <= '0;
                        if (r_bar_idx != 3'd7) begin
                            r_bar_idx <= r_bar_idx + 3'd1;
                        end
                    end else begin
                        r_bar_cnt <= r_bar_cnt + BCW'(1);
                    end
                end
            end
        end
    end

    logic           w_de;
    logic           w_hs;
    logic           w_vs;
    logic [C_W-1:0] w_ramp_g;
    logic [HW-1:0]  w_mv;
    logic           w_xhatch;
    logic [C_W-1:0] w_r;
    logic [C_W-1:0] w_g;
    logic [C_W-1:0] w_b;

    assign w_de     = (r_h < L_H_ACT) && (r_v < L_V_ACT);
    assign w_hs     = (r_h >= L_HS_ON) && (r_h < L_HS_OFF);
    assign w_vs     = (r_v >= L_VS_ON) && (r_v < L_VS_OFF);
    assign w_ramp_g = C_W'(r_h) + C_W'(r_v) + C_W'(r_f);
    assign w_mv     = r_h - (HW'(r_f) << 2);
    assign w_xhatch = (r_h[3:0] == 4'd0) || (r_v[3:0] == 4'd0) ||
                      (r_h == L_H_ACT_M1) || (r_v == L_V_ACT_M1);

    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        case (w_mode)
            3'd0: begin
                w_r = C_W'(r_h);
                w_g = w_ramp_g;
                w_b = C_W'(r_v);
            end
            3'd1: begin
                // Bar order W,Y,C,G,M,R,B,K maps each component onto one index bit.
                w_r = {C_W{~r_bar_idx[1]}};
                w_g = {C_W{~r_bar_idx[2]}};
                w_b = {C_W{~r_bar_idx[0]}};
            end
            3'd2: begin
                w_r = {C_W{r_h[4] ^ r_v[4]}};
                w_g = {C_W{r_h[4] ^ r_v[4]}};
                w_b = {C_W{r_h[4] ^ r_v[4]}};
            end
            3'd3: begin
                w_r = {C_W{w_xhatch}};
                w_g = {C_W{w_xhatch}};
                w_b = {C_W{w_xhatch}};
            end
            3'd4: begin
                {w_r, w_g, w_b} = SOLID_i;
            end
            3'd5: begin
                w_r = {C_W{w_mv < HW'(16)}};
                w_g = {C_W{w_mv < HW'(16)}};
                w_b = {C_W{w_mv < HW'(16)}};
            end
            default: begin
                w_r = '0;
                w_g = '0;
                w_b = '0;
            end
        endcase
        if (!w_de) begin
            w_r = '0;
            w_g = '0;
            w_b = '0;
        end
    end

    // Pixel stage: one enabled cycle behind the raw counters
    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            HS_o    <= 1'b0;
            VS_o    <= 1'b0;
            DE_o    <= 1'b0;
            FRAME_o <= 1'b0;
            QQs_R_o <= '0;
            QQs_G_o <= '0;
            QQs_B_o <= '0;
        end else if (CK_EE_i) begin
            HS_o    <= w_hs;
            VS_o    <= w_vs;
            DE_o    <= w_de;
            FRAME_o <= w_sof;
            QQs_R_o <= w_r;
            QQs_G_o <= w_g;
            QQs_B_o <= w_b;
        end
    end

    assign HCTRs_o = r_h;
    assign VCTRs_o = r_v;
    assign FCTRs_o = r_f;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Scoreboard bench for test_pattern_gen on a reduced 100x30 raster with a 3-bit frame
// counter; expected items are keyed by enabled-cycle count since reset release.
module tb_test_pattern_gen;

    localparam int HT  = 100;
    localparam int TFW = 3;

    logic          CK_i    = 1'b0;
    logic          RST_i   = 1'b1;
    logic          CK_EE_i = 1'b1;
    logic          XVRST_i = 1'b1;
    logic [2:0]    MODE_i  = 3'd0;
    logic [23:0]   SOLID_i = 24'h0;
    logic          HS_o, VS_o, DE_o, FRAME_o;
    logic [7:0]    QQs_R_o, QQs_G_o, QQs_B_o;
    logic [9:0]    HCTRs_o, VCTRs_o;
    logic [TFW-1:0] FCTRs_o;

    test_pattern_gen #(
        .C_W(8), .HW(10), .VW(10), .FW(TFW),
        .H_TOTAL(HT), .H_ACT(80), .H_SYNC_START(84), .H_SYNC_LEN(6),
        .V_TOTAL(30), .V_ACT(24), .V_SYNC_START(26), .V_SYNC_LEN(2),
        .BAR_W(10)
    ) dut (
        .CK_i(CK_i), .RST_i(RST_i), .CK_EE_i(CK_EE_i), .XVRST_i(XVRST_i),
        .MODE_i(MODE_i), .SOLID_i(SOLID_i),
        .HS_o(HS_o), .VS_o(VS_o), .DE_o(DE_o),
        .QQs_R_o(QQs_R_o), .QQs_G_o(QQs_G_o), .QQs_B_o(QQs_B_o),
        .HCTRs_o(HCTRs_o), .VCTRs_o(VCTRs_o), .FCTRs_o(FCTRs_o), .FRAME_o(FRAME_o)
    );

    always #5 CK_i = ~CK_i;

    typedef struct {
        int          n;
        logic [55:0] exp;
        logic [55:0] msk;
        string       nm;
    } item_t;

    item_t       q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ecyc    = 0;
    int          last_mon = -1;
    int          last_st  = -1;
    int          de_cnt = 0, hs_cnt = 0, vs_cnt = 0;
    logic [55:0] act;

    // {H, V, F(8), HS, VS, DE, FRAME, R, G, B}
    assign act = {HCTRs_o, VCTRs_o, {(8-TFW){1'b0}}, FCTRs_o, HS_o, VS_o, DE_o, FRAME_o,
                  QQs_R_o, QQs_G_o, QQs_B_o};

    always @(posedge CK_i) begin
        if (RST_i)        ecyc <= 0;
        else if (CK_EE_i) ecyc <= ecyc + 1;
    end

    function automatic int at(input int base, input int h, input int v);
        return base + v * HT + h + 1;
    endfunction

    function automatic void push(input int n, input string nm, input logic [55:0] e,
                                 input logic [55:0] m);
        item_t it;
        it.n = n; it.nm = nm; it.exp = e; it.msk = m;
        q.push_back(it);
    endfunction

    function automatic void p_ctr(input int n, input string nm, input int h, input int v,
                                  input int f);
        push(n, nm, {10'(h), 10'(v), 8'(f), 28'h0}, 56'hFFFFFFF0000000);
    endfunction

    function automatic void p_pix(input int n, input string nm, input bit de, input bit fr,
                                  input logic [23:0] rgb);
        push(n, nm, {30'h0, de, fr, rgb}, 56'h00000003FFFFFF);
    endfunction

    function automatic void p_syn(input int n, input string nm, input bit hs, input bit vs);
        push(n, nm, {28'h0, hs, vs, 26'h0}, 56'h0000000C000000);
    endfunction

    task automatic chk(input string nm, input logic [55:0] e, input logic [55:0] m);
        n_tests++;
        if ((act & m) !== (e & m)) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", nm, ecyc, act & m, e & m);
        end
    endtask

    task automatic cmp_int(input string nm, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    task automatic wait_e(input int t);
        int g = 0;
        while (ecyc < t && g < 20000) begin
            @(negedge CK_i);
            g++;
        end
        if (ecyc != t) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_cycle: got cycle %0d, expected %0d", ecyc, t);
        end
    endtask

    // Monitor: once per enabled cycle, retire every item due at this cycle.
    always @(negedge CK_i) begin
        if (RST_i) begin
            last_mon = -1;
        end else if (ecyc != last_mon) begin
            last_mon = ecyc;
            while (q.size() > 0 && q[0].n <= ecyc) begin
                if (q[0].n < ecyc) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s: item for cycle %0d missed at cycle %0d",
                             q[0].nm, q[0].n, ecyc);
                end else begin
                    chk(q[0].nm, q[0].exp, q[0].msk);
                end
                void'(q.pop_front());
            end
        end
    end

    // Frame-0 occupancy counters for DE/HS/VS
    always @(negedge CK_i) begin
        if (RST_i) begin
            last_st = -1; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        end else if (ecyc != last_st && ecyc >= 1 && ecyc <= 3000) begin
            last_st = ecyc;
            de_cnt += int'(DE_o);
            hs_cnt += int'(HS_o);
            vs_cnt += int'(VS_o);
        end
    end

    initial begin
        int b;
        b = 24531;
        repeat (3) @(posedge CK_i);
        @(negedge CK_i) RST_i = 1'b0;
        repeat (50) @(negedge CK_i);
        RST_i = 1'b1;
        repeat (3) begin
            @(negedge CK_i);
            chk("reset_zero", 56'h0, {56{1'b1}});
        end

        // frame 0: ramp, timing boundaries
        p_ctr(1, "h_after_rel_1", 1, 0, 0);
        p_pix(at(0, 0, 0), "first_pix", 1, 1, 24'h000000);
        p_syn(1, "first_sync", 0, 0);
        p_ctr(2, "h_after_rel_2", 2, 0, 0);
        p_pix(at(0, 79, 0), "de_last_col", 1, 0, 24'h4F4F00);
        p_pix(at(0, 80, 0), "de_off_col", 0, 0, 24'h000000);
        p_syn(at(0, 83, 0), "hs_pre", 0, 0);
        p_syn(at(0, 84, 0), "hs_on", 1, 0);
        p_syn(at(0, 89, 0), "hs_last", 1, 0);
        p_syn(at(0, 90, 0), "hs_off", 0, 0);
        p_pix(at(0, 5, 3), "ramp_5_3", 1, 0, 24'h050803);
        p_pix(at(0, 50, 20), "ramp_after_modechg", 1, 0, 24'h324614);
        p_pix(at(0, 0, 23), "de_last_line", 1, 0, 24'h001717);
        p_pix(at(0, 0, 24), "de_off_line", 0, 0, 24'h000000);
        p_syn(at(0, 99, 25), "vs_pre", 0, 0);
        p_syn(at(0, 0, 26), "vs_on", 0, 1);
        p_syn(at(0, 99, 27), "vs_last", 0, 1);
        p_syn(at(0, 0, 28), "vs_off", 0, 0);
        p_ctr(2999, "ctr_frame_end", 99, 29, 0);
        p_ctr(3000, "ctr_f_inc", 0, 0, 1);
        // frame 1: checker
        p_pix(at(3000, 0, 0), "chk_first", 1, 1, 24'h000000);
        p_pix(at(3000, 16, 0), "chk_16_0", 1, 0, 24'hFFFFFF);
        p_pix(at(3000, 5, 3), "chk_5_3", 1, 0, 24'h000000);
        p_pix(at(3000, 0, 16), "chk_0_16", 1, 0, 24'hFFFFFF);
        p_pix(at(3000, 16, 16), "chk_16_16", 1, 0, 24'h000000);
        // frame 2: bars
        p_pix(at(6000, 9, 0), "bar_white_end", 1, 0, 24'hFFFFFF);
        p_pix(at(6000, 10, 0), "bar_yellow", 1, 0, 24'hFFFF00);
        p_pix(at(6000, 20, 0), "bar_cyan", 1, 0, 24'h00FFFF);
        p_pix(at(6000, 45, 0), "bar_magenta", 1, 0, 24'hFF00FF);
        p_pix(at(6000, 50, 0), "bar_red", 1, 0, 24'hFF0000);
        p_pix(at(6000, 69, 0), "bar_blue", 1, 0, 24'h0000FF);
        p_pix(at(6000, 70, 0), "bar_black", 1, 0, 24'h000000);
        p_pix(at(6000, 80, 0), "bar_blank", 0, 0, 24'h000000);
        p_pix(at(6000, 9, 1), "bar_l1_white", 1, 0, 24'hFFFFFF);
        p_pix(at(6000, 10, 1), "bar_l1_yellow", 1, 0, 24'hFFFF00);
        p_pix(at(6000, 79, 5), "bar_black_end", 1, 0, 24'h000000);
        // frame 3: crosshatch
        p_pix(at(9000, 16, 3), "xh_col16", 1, 0, 24'hFFFFFF);
        p_pix(at(9000, 79, 3), "xh_lastcol", 1, 0, 24'hFFFFFF);
        p_pix(at(9000, 0, 5), "xh_col0", 1, 0, 24'hFFFFFF);
        p_pix(at(9000, 5, 5), "xh_blank", 1, 0, 24'h000000);
        p_pix(at(9000, 5, 16), "xh_row16", 1, 0, 24'hFFFFFF);
        p_pix(at(9000, 17, 17), "xh_blank2", 1, 0, 24'h000000);
        p_pix(at(9000, 5, 23), "xh_lastrow", 1, 0, 24'hFFFFFF);
        // frame 4: solid
        p_pix(at(12000, 3, 3), "solid", 1, 0, 24'h123456);
        p_pix(at(12000, 85, 3), "solid_blank", 0, 0, 24'h000000);
        // frame 5: moving bar, F=5 -> H 20..35 white
        p_pix(at(15000, 19, 0), "mv_pre", 1, 0, 24'h000000);
        p_pix(at(15000, 20, 0), "mv_start", 1, 0, 24'hFFFFFF);
        p_pix(at(15000, 35, 0), "mv_end", 1, 0, 24'hFFFFFF);
        p_pix(at(15000, 36, 0), "mv_post", 1, 0, 24'h000000);
        // frame 6: black, frame 7: ramp with F=7
        p_pix(at(18000, 5, 5), "mode6_black", 1, 0, 24'h000000);
        p_pix(at(21000, 1, 2), "ramp_f7", 1, 0, 24'h010A02);
        p_ctr(23999, "ctr_f7_end", 99, 29, 7);
        p_ctr(24000, "ctr_f_wrap", 0, 0, 0);
        // restart at H=30, V=5 of frame 8
        p_pix(at(24000, 30, 5), "pix_at_restart", 1, 0, 24'h1E2305);
        p_ctr(b, "ctr_restart", 0, 0, 0);
        p_pix(at(b, 0, 0), "restart_frame_pulse", 1, 1, 24'h123456);
        p_ctr(b + 1, "ctr_after_restart", 1, 0, 0);
        p_pix(at(b, 5, 0), "restart_relatch", 1, 0, 24'h123456);
        p_ctr(b + 150, "no_second_restart", 50, 1, 0);
        p_ctr(b + 210, "ctr_pre_freeze", 10, 2, 0);
        p_pix(b + 210, "pix_pre_freeze", 1, 0, 24'h123456);
        p_ctr(b + 211, "ctr_post_freeze", 11, 2, 0);
        p_ctr(b + 2999, "ctr_restart_frame_end", 99, 29, 0);
        p_ctr(b + 3000, "ctr_restart_f_inc", 0, 0, 1);

        RST_i = 1'b0;
        wait_e(1000);  MODE_i = 3'd2;
        wait_e(3001);
        cmp_int("de_per_frame", de_cnt, 1920);
        cmp_int("hs_per_frame", hs_cnt, 180);
        cmp_int("vs_per_frame", vs_cnt, 200);
        wait_e(4000);  MODE_i = 3'd1;
        wait_e(7000);  MODE_i = 3'd3;
        wait_e(10000); MODE_i = 3'd4; SOLID_i = 24'h123456;
        wait_e(13000); MODE_i = 3'd5;
        wait_e(16000); MODE_i = 3'd6;
        wait_e(19000); MODE_i = 3'd0;
        wait_e(24200); MODE_i = 3'd4;
        wait_e(24530); XVRST_i = 1'b0;
        wait_e(b + 210);
        CK_EE_i = 1'b0;
        repeat (5) begin
            @(negedge CK_i);
            chk("freeze", {10'd10, 10'd2, 8'd0, 4'b0010, 24'h123456}, {56{1'b1}});
        end
        CK_EE_i = 1'b1;
        wait_e(b + 3001);
        repeat (3) @(negedge CK_i);
        while (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: never checked, due at cycle %0d", q[0].nm, q[0].n);
            void'(q.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
